// File: rtl/video_timing_pkg.sv
// video_timing_pkg: horizontal slot constants, RAM widths and the CPU access state type
package video_timing_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
  localparam logic [3:0] P_VID_DEF = 4'd0;
  localparam logic [3:0] P_CPU_DEF = 4'd8;
  localparam int CPU_LEN_DEF = 4;
  localparam int MAX_WAIT_DEF = 31;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} cpu_state_t;
endpackage

// File: rtl/vram_slot_decode.sv
// vram_slot_decode: maps the 16-clock character phase and vblank onto video/CPU slot qualifiers
module vram_slot_decode
  import video_timing_pkg::*;
#(
  parameter logic [3:0] P_VID = P_VID_DEF,
  parameter logic [3:0] P_CPU = P_CPU_DEF,
  parameter int CPU_LEN = CPU_LEN_DEF
) (
  input  logic [3:0] hphase,
  input  logic       vblank,
  output logic       vid_slot,
  output logic       cpu_slot_ok
);
  logic [3:0] off;
  always_comb begin
    off = hphase - P_CPU;
    vid_slot = (hphase == P_VID) && !vblank;
    cpu_slot_ok = vblank || ({1'b0, off} < 5'(CPU_LEN));
  end
endmodule

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: time-slot sharing of the playfield RAM between video fetch and CPU req/ack
module vram_slot_arbiter
  import video_timing_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter logic [3:0] P_VID = P_VID_DEF,
  parameter logic [3:0] P_CPU = P_CPU_DEF,
  parameter int CPU_LEN = CPU_LEN_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk_12mhz,
  input  logic          reset,
  input  logic [3:0]    hphase,
  input  logic          vblank,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic          cpu_overrun,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam logic [3:0] VID_OFF = P_VID - P_CPU;
  if (CPU_LEN > 16 || (CPU_LEN > 0 && int'(VID_OFF) < CPU_LEN)) begin : g_bad_window
    $error("CPU window overlaps the video slot");
  end
  cpu_state_t state, state_nxt;
  logic vid_slot, cpu_slot_ok, grant, vid_p1, vid_p2, op_we;
  logic [4:0] wait_cnt, wait_nxt;
  vram_slot_decode #(.P_VID(P_VID), .P_CPU(P_CPU), .CPU_LEN(CPU_LEN)) u_decode (
    .hphase(hphase),
    .vblank(vblank),
    .vid_slot(vid_slot),
    .cpu_slot_ok(cpu_slot_ok)
  );
  always_comb begin
    grant = (state == IDLE) && cpu_req && !cpu_ack && !vid_slot && cpu_slot_ok;
    state_nxt = state == IDLE ? (grant ? ISSUE : IDLE)
              : state == ISSUE ? WAIT
              : state == WAIT ? CAPTURE : IDLE;
    cpu_wait = cpu_req && !cpu_ack;
    wait_nxt = !cpu_wait ? 5'd0 : (wait_cnt == 5'd31 ? wait_cnt : wait_cnt + 5'd1);
  end
  // video stages run on their own so a vblank rising mid-fetch still delivers the data
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      vid_p1 <= 1'b0;
      vid_p2 <= 1'b0;
      vid_valid <= 1'b0;
      vid_data <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      op_we <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      wait_cnt <= '0;
      cpu_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      vid_p1 <= vid_slot;
      vid_p2 <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) vid_data <= ram_rdata;
      ram_we <= grant && cpu_we;
      if (vid_slot) ram_addr <= vid_addr;
      else if (grant) begin
        ram_addr <= cpu_addr;
        ram_wdata <= cpu_wdata;
        op_we <= cpu_we;
      end
      cpu_ack <= state == WAIT;
      if (state == WAIT && !op_we) cpu_rdata <= ram_rdata;
      wait_cnt <= wait_nxt;
      cpu_overrun <= cpu_overrun || (wait_nxt >= 5'(MAX_WAIT));
    end
  end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed slot-timing checks plus randomized traffic against a transaction-level model
module tb_vram_slot_arbiter;
  localparam int P_VID = 0, P_CPU = 8, CPU_LEN = 4, MAX_WAIT = 31;
  logic clk = 0, rst = 1;
  logic [3:0] hphase = 0;
  logic vblank = 0, cpu_req = 0, cpu_we = 0, s_req = 0, zero1 = 0;
  logic [9:0] vid_addr = 0, cpu_addr = 0, zero10 = 0, ram_addr, s_ra;
  logic [7:0] cpu_wdata = 0, zero8 = 0, vid_data, cpu_rdata, ram_wdata, ram_rdata, s_vd, s_rd, s_rwd;
  logic vid_valid, cpu_ack, cpu_wait, cpu_overrun, ram_we, s_vv, s_ack, s_wait, s_ovr, s_rwe;
  int n_chk = 0, n_pass = 0, acks;
  bit chk_en = 0;

  vram_slot_arbiter dut (
    .clk_12mhz(clk), .reset(rst), .hphase(hphase), .vblank(vblank), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait), .cpu_overrun(cpu_overrun), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // empty CPU window: a held request can never be served
  vram_slot_arbiter #(.CPU_LEN(0)) dut_s (
    .clk_12mhz(clk), .reset(rst), .hphase(hphase), .vblank(zero1), .vid_addr(zero10),
    .vid_data(s_vd), .vid_valid(s_vv), .cpu_req(s_req), .cpu_we(zero1),
    .cpu_addr(zero10), .cpu_wdata(zero8), .cpu_rdata(s_rd), .cpu_ack(s_ack),
    .cpu_wait(s_wait), .cpu_overrun(s_ovr), .ram_addr(s_ra), .ram_we(s_rwe),
    .ram_wdata(s_rwd), .ram_rdata(zero8)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] seed(int i);
    return i == 'h155 ? 8'hA5 : i == 'h3FF ? 8'h5C : 8'(i * 37 + 11);
  endfunction

  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 1024; i++) ram[i] <= seed(i);
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
  endtask

  // transaction model: memory contents follow grant order, results land at fixed edge offsets
  logic [7:0] mem [1024];
  logic [7:0] m_vd, m_rd, m_wd, vid_buf, acc_buf;
  logic [9:0] m_ra;
  logic m_vv, m_ack, m_we, m_ovr, acc_we;
  int n, vid_due, ack_due, free_at, m_pend;

  task automatic model_step();
    logic vid_go, cpu_go, win;
    if (rst) begin
      {m_vv, m_ack, m_we, m_ovr, acc_we} = '0;
      m_vd = 0; m_rd = 0; m_wd = 0; m_ra = 0;
      n = 0; vid_due = -1; ack_due = -1; free_at = 0; m_pend = 0;
      for (int i = 0; i < 1024; i++) mem[i] = seed(i);
    end else begin
      n++;
      m_pend = (cpu_req && !m_ack) ? (m_pend < 31 ? m_pend + 1 : 31) : 0;
      if (m_pend >= MAX_WAIT) m_ovr = 1;
      vid_go = int'(hphase) == P_VID && !vblank;
      win = vblank || ((int'(hphase) - P_CPU + 16) % 16) < CPU_LEN;
      cpu_go = cpu_req && !m_ack && n >= free_at && !vid_go && win;
      m_vv = n == vid_due;
      if (m_vv) m_vd = vid_buf;
      if (vid_go) begin
        vid_due = n + 2;
        vid_buf = mem[vid_addr];
      end
      m_ack = n == ack_due;
      if (m_ack && !acc_we) m_rd = acc_buf;
      m_we = cpu_go && cpu_we;
      if (vid_go) m_ra = vid_addr;
      else if (cpu_go) m_ra = cpu_addr;
      if (cpu_go) begin
        m_wd = cpu_wdata;
        ack_due = n + 2;
        free_at = n + 4;
        acc_we = cpu_we;
        if (cpu_we) mem[cpu_addr] = cpu_wdata;
        else acc_buf = mem[cpu_addr];
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("vid_valid", 32'(vid_valid), 32'(m_vv));
      check("vid_data", 32'(vid_data), 32'(m_vd));
      check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_rd));
      check("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !m_ack));
      check("cpu_overrun", 32'(cpu_overrun), 32'(m_ovr));
      check("ram_addr", 32'(ram_addr), 32'(m_ra));
      check("ram_we", 32'(ram_we), 32'(m_we));
      check("ram_wdata", 32'(ram_wdata), 32'(m_wd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1 hphase = hphase + 4'd1;
  endtask

  task automatic wait_hp(logic [3:0] v);
    for (int i = 0; i < 16 && hphase != v; i++) tick();
  endtask

  task automatic new_op();
    cpu_we = 1'($urandom_range(1));
    cpu_addr = $urandom_range(1) ? 10'($urandom_range(15)) : 10'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  initial begin
    repeat (2) tick();
    chk_en = 1;
    check("rst_vid_valid", 32'(vid_valid), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_overrun", 32'(cpu_overrun), 0);
    wait_hp(14);
    rst = 0;
    vid_addr = 10'h155;
    wait_hp(0);
    tick();
    check("vid_issue_addr", 32'(ram_addr), 32'h155);
    check("vid_issue_we", 32'(ram_we), 0);
    tick();
    check("vid_valid_early", 32'(vid_valid), 0);
    tick();
    check("vid_valid_h3", 32'(vid_valid), 1);
    check("vid_data_h3", 32'(vid_data), 32'hA5);
    acks = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      acks += int'(vid_valid);
    end
    check("vid_pulses_32clk", 32'(acks), 2);
    wait_hp(2);
    cpu_we = 0; cpu_addr = 10'h3FF; cpu_req = 1;
    #1;
    for (int i = 0; i < 9; i++) begin
      check("cpu_wait_hold", 32'(cpu_wait), 1);
      check("cpu_ack_early", 32'(cpu_ack), 0);
      if (hphase == 4'd9) check("cpu_grant_addr", 32'(ram_addr), 32'h3FF);
      tick();
    end
    check("cpu_ack_h11", 32'(cpu_ack), 1);
    check("cpu_rdata_h11", 32'(cpu_rdata), 32'h5C);
    check("cpu_wait_ack", 32'(cpu_wait), 0);
    cpu_req = 0;
    tick();
    check("cpu_ack_pulse", 32'(cpu_ack), 0);
    wait_hp(0);
    vblank = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 8'h7E; cpu_req = 1;
    tick();
    check("vb_ram_we", 32'(ram_we), 1);
    check("vb_ram_addr", 32'(ram_addr), 32'h010);
    check("vb_ram_wdata", 32'(ram_wdata), 32'h7E);
    tick();
    check("vb_ram_we_off", 32'(ram_we), 0);
    tick();
    check("vb_wr_ack", 32'(cpu_ack), 1);
    check("vb_no_video", 32'(vid_valid), 0);
    cpu_req = 0;
    tick();
    cpu_we = 0; cpu_req = 1;
    repeat (3) tick();
    check("vb_rd_ack", 32'(cpu_ack), 1);
    check("vb_readback", 32'(cpu_rdata), 32'h7E);
    cpu_req = 0;
    vblank = 0;
    tick();
    s_req = 1;
    repeat (30) tick();
    check("starve_30", 32'(s_ovr), 0);
    tick();
    check("starve_31", 32'(s_ovr), 1);
    s_req = 0;
    repeat (5) tick();
    check("starve_sticky", 32'(s_ovr), 1);
    wait_hp(0);
    cpu_we = 0; cpu_addr = 10'($urandom); cpu_req = 1;
    acks = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        check("b2b_ack_phase", 32'(hphase), 11);
      end
    end
    check("b2b_acks", 32'(acks), 3);
    cpu_req = 0;
    tick();
    wait_hp(8);
    cpu_addr = 10'h155; cpu_req = 1;
    repeat (2) tick();
    rst = 1;
    cpu_req = 0;
    #1;
    check("mid_rst_ack", 32'(cpu_ack), 0);
    check("mid_rst_rdata", 32'(cpu_rdata), 0);
    check("mid_rst_vid_data", 32'(vid_data), 0);
    check("mid_rst_ram_addr", 32'(ram_addr), 0);
    check("mid_rst_s_ovr", 32'(s_ovr), 0);
    repeat (3) tick();
    rst = 0;
    acks = 0;
    repeat (20) begin
      tick();
      acks += int'(cpu_ack);
    end
    check("no_ack_after_rst", 32'(acks), 0);
    check("ovr_after_rst", 32'(cpu_overrun), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) vblank = ~vblank;
      vid_addr = 10'($urandom);
      if (cpu_req && cpu_ack) begin
        if ($urandom_range(3) != 0) cpu_req = 0;
        else new_op();
      end else if (!cpu_req && $urandom_range(3) == 0) begin
        new_op();
        cpu_req = 1;
      end
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
Time-slot arbiter that shares the single-port playfield RAM between the video fetch path and the CPU. Slots are derived from the low bits of the horizontal timing chain (6MHz, 1H, 2H, 4H). Video owns a fixed read slot in each 16-clock character cell. The CPU is granted a fixed window per cell, or any cycle during vblank, through a req/ack handshake that the CPU side can use for wait-state stretching.

Parameters:
AW, 10, RAM address width
DW, 8, RAM data width
P_VID, 0, hphase value at which the video read issues
P_CPU, 8, first hphase of the CPU window
CPU_LEN, 4, CPU window length in clocks; window [P_CPU, P_CPU+CPU_LEN-1] must not contain P_VID (elaboration check)
MAX_WAIT, 31, request-pending cycle count that sets the overrun flag

Ports:
clk_12mhz  in  1  master 12MHz clock
reset  in  1  asynchronous, active-high reset
hphase  in  4  {4H,2H,1H,6MHz}, increments by 1 every clk_12mhz
vblank  in  1  registered vblank from the vertical PROM latch
vid_addr  in  AW  playfield address from the video address generator
vid_data  out  DW  latched video read data
vid_valid  out  1  one-cycle pulse when vid_data updates
cpu_req  in  1  level request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req && !cpu_ack
cpu_addr  in  AW  CPU address; stable as above
cpu_wdata  in  DW  CPU write data; stable as above
cpu_rdata  out  DW  CPU read data
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  cpu_req & ~cpu_ack (combinational), for CPU clock stretch
cpu_overrun  out  1  sticky starvation flag
ram_addr  out  AW  registered RAM address
ram_we  out  1  registered RAM write strobe
ram_wdata  out  DW  registered RAM write data
ram_rdata  in  DW  synchronous RAM output; valid one edge after ram_addr is captured

Behaviour:
- Reset (async, active-high): all registered outputs 0; FSM to IDLE; wait counter 0; cpu_overrun cleared. An in-flight access is dropped and no ack is generated.
- Issue rule: at most one RAM issue per edge. Video has priority.
- Video issue, edge E0 (hphase==P_VID and vblank==0):
  - ram_addr<=vid_addr, ram_we<=0.
  - E1: RAM captures the address.
  - E2: vid_data<=ram_rdata, vid_valid<=1 for one cycle, so vid_valid is high while hphase==P_VID+3.
  - With vblank==1 at E0 there is no video issue and vid_valid stays 0.
- Video pipeline is independent of the CPU FSM. Its E1/E2 stages complete even if vblank rises after E0.
- CPU FSM states IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE->ISSUE on an edge where cpu_req==1, cpu_ack==0, no video issue this edge, and (hphase in window or vblank==1). On that edge: ram_addr<=cpu_addr, ram_we<=cpu_we, ram_wdata<=cpu_wdata.
  - ISSUE->WAIT: ram_we<=0.
  - WAIT->CAPTURE: for a read, cpu_rdata<=ram_rdata; for a write, cpu_rdata holds its previous value. cpu_ack<=1.
  - CAPTURE->IDLE: cpu_ack<=0. Requester drops cpu_req in this cycle. A request still high is treated as a new access, eligible no earlier than the next edge.
- Grant latency: 3 edges from grant to cpu_ack high.
- Window wrap: hphase wraps 15->0. Window arithmetic is modulo 16.
- Wait counter: 5-bit saturating. Counts each edge with cpu_req && !cpu_ack; clears on cpu_ack or !cpu_req. Reaching MAX_WAIT sets cpu_overrun, which holds until reset.
- When no issue occurs on an edge: ram_we<=0 and ram_addr holds its value.

Decomposition:
- Package video_timing_pkg: hphase constants (P_VID, P_CPU, CPU_LEN), CPU FSM state enum, AW/DW defaults.
- One sub-module, vram_slot_decode: combinational; hphase, vblank -> vid_slot, cpu_slot_ok.
- FSM, video pipeline and wait counter live in vram_slot_arbiter.

Test Plan:
- Reset mid-access: assert reset during WAIT of a CPU read -> all outputs 0 immediately; no cpu_ack after release; cpu_overrun=0.
- Video read: vblank=0, vid_addr=0x155, RAM[0x155]=0xA5 -> ram_addr=0x155 after the hphase==0 edge; vid_valid high exactly at hphase==3 with vid_data=0xA5; one pulse per 16 clocks.
- CPU read in window: cpu_req raised at hphase=2, addr=0x3FF, RAM=0x5C -> grant at the hphase==8 edge; cpu_ack at hphase==11 with cpu_rdata=0x5C; cpu_wait high from hphase=2 through 10.
- CPU write during vblank: vblank=1, cpu_req at hphase=0, we=1, addr=0x010, data=0x7E -> immediate grant; ram_we high one cycle; no vid_valid; readback at 0x010 returns 0x7E.
- Priority/back-to-back: vblank=0, CPU req held with no drop after ack -> second grant never issues at hphase==0; all issues fall within hphase 8..11.
- Starvation: CPU_LEN=0 override, cpu_req held 31 clocks -> cpu_overrun=1 and stays 1 after cpu_req drops until reset.
